vector_issue_sequencer: RTL and testbench
=========================================

Name: vector_issue_sequencer

Overview:
Sequences one decoded vector instruction across the lane datapath of the vector processor. It accepts an instruction from decode over a valid/ready handshake and holds fetch stalled while it runs. It issues element groups of LANES elements per cycle to the lane ALUs, then waits out the lane pipeline latency. Finally it pulses completion to writeback. It sits between decode and the lane execute stage.

Parameters:
NUM_ELEM, 8, maximum elements per vector register
LANES, 4, elements issued per cycle (NUM_ELEM multiple of LANES)
PIPE_LAT, 3, lane pipeline depth in cycles, from issue to result valid
REG_W, 4, vector register address width
OP_W, 5, opcode width
PC_W, 21, program counter width
VL_W, $clog2(NUM_ELEM+1), vector length width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  decode presents an instruction
in_ready  out  1  sequencer can accept (high only in IDLE)
in_op  in  OP_W  vector opcode
in_vs1  in  REG_W  source register 1
in_vs2  in  REG_W  source register 2
in_vd  in  REG_W  destination register
in_vlen  in  VL_W  requested vector length
in_pc  in  PC_W  PC of the instruction
lane_valid  out  LANES  per-lane issue strobe
lane_ready  in  1  lanes accept the current group
lane_op  out  OP_W  opcode to lanes
lane_vs1 / lane_vs2 / lane_vd  out  REG_W each  register addresses to lanes
elem_base  out  VL_W  index of element in lane 0
stall_fetch  out  1  hold PC/fetch
done  out  1  one-cycle completion pulse
done_vd  out  REG_W  destination register of the completed instruction
done_pc  out  PC_W  PC of the completed instruction

Behaviour:
- Reset (rst_n low at clk edge):
  - state to IDLE.
  - lane_valid, elem_base, done, done_vd, done_pc, and all latched fields go to 0.
  - in_ready goes to 1 and stall_fetch to 0.
  - Reset mid-operation abandons the instruction; no done pulse.
- States: IDLE, ISSUE, DRAIN, DONE (state enum encoding).
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch op/vs1/vs2/vd/pc.
  - Set vlen_q = min(in_vlen, NUM_ELEM) and elem_base=0.
  - Next state is ISSUE if vlen_q>0, else DONE.
- ISSUE:
  - lane_valid[i] = (elem_base+i < vlen_q).
  - When lane_ready=1: if elem_base+LANES >= vlen_q, go to DRAIN and load drain counter with PIPE_LAT-1; else elem_base += LANES.
  - When lane_ready=0: all lane outputs hold stable.
- DRAIN:
  - lane_valid=0.
  - Counter decrements each cycle; at 0, go to DONE.
  - Total DRAIN occupancy is PIPE_LAT cycles.
- DONE:
  - done=1 for exactly one cycle, with done_vd/done_pc valid.
  - Next state is IDLE.
- stall_fetch = (state != IDLE).
- in_valid while busy: ignored, since in_ready=0. Decode must hold the instruction.
- lane_op/vs1/vs2/vd are driven from the latched values in all states; they are don't-care outside ISSUE but stable.
- Latency for vlen=NUM_ELEM=8, LANES=4, lane_ready=1, with accept at edge 0:
  - ISSUE cycles 1–2.
  - DRAIN cycles 3–5.
  - done in cycle 6.
  - in_ready in cycle 7.
- Arithmetic: elem_base is VL_W wide and unsigned; the comparison elem_base+i is done in VL_W+1 bits so it cannot wrap.

Optional Feature:
VSEQ_MASK_EN:
- Defined: adds input in_mask [NUM_ELEM], latched on accept. lane_valid[i] is additionally ANDed with mask_q[elem_base+i]. A group whose lanes are all masked still takes one ISSUE cycle with lane_valid=0 (no group skipping), so latency is unchanged.
- Undefined: no in_mask port; all elements below vlen_q are issued.

Decomposition:
- Package vproc_pkg: state enum seq_state_t, opcode type vop_t, and constants NUM_ELEM, LANES, REG_W, PC_W.
- One natural sub-module, vseq_drain_counter: loadable down-counter with a zero flag, used for DRAIN.

Test Plan:
- vlen=8, lane_ready=1 → lane_valid=4'b1111 with elem_base 0 then 4 (cycles 1–2), done=1 in cycle 6 with done_vd=in_vd, stall_fetch high in cycles 1–6.
- vlen=5 → groups 4'b1111 @base0 and 4'b0001 @base4; done in cycle 6.
- vlen=0 → no lane_valid; done in cycle 1; in_ready in cycle 2. vlen=12 → clamped to 8, same timing as the first scenario.
- lane_ready low for 2 cycles during group 0 → lane_valid/elem_base held; done delayed by exactly 2 cycles (cycle 8).
- rst_n low in ISSUE cycle 2 → next cycle IDLE, lane_valid=0, stall_fetch=0, no done; a new instruction is accepted normally.
- VSEQ_MASK_EN, vlen=8, mask=8'b0101_0000 → group 0 lane_valid=4'b0000, group 1 4'b0101; done in cycle 6.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared types and sizing for the vector issue sequencer and its neighbours.
// Element/lane geometry, register/PC widths and the sequencer state encoding.
package vproc_pkg;

    localparam int NUM_ELEM = 8;
    localparam int LANES    = 4;
    localparam int PIPE_LAT = 3;
    localparam int REG_W    = 4;
    localparam int OP_W     = 5;
    localparam int PC_W     = 21;
    localparam int VL_W     = $clog2(NUM_ELEM + 1);

    typedef logic [OP_W-1:0] vop_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    // Requests longer than a register are trimmed to the register length.
    function automatic logic [VL_W-1:0] clamp_vlen(input logic [VL_W-1:0] v);
        return (int'(v) > NUM_ELEM) ? VL_W'(NUM_ELEM) : v;
    endfunction

endpackage

// File: rtl/vector_issue_sequencer_if.sv
// Decode -> sequencer -> lanes/writeback signal bundle; VSEQ_MASK_EN adds in_mask.
// master = decode/lane/writeback side, slave = the sequencer.
interface vector_issue_sequencer_if;
    import vproc_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    vop_t                 in_op;
    logic [REG_W-1:0]     in_vs1;
    logic [REG_W-1:0]     in_vs2;
    logic [REG_W-1:0]     in_vd;
    logic [VL_W-1:0]      in_vlen;
    logic [PC_W-1:0]      in_pc;
`ifdef VSEQ_MASK_EN
    logic [NUM_ELEM-1:0]  in_mask;
`endif
    logic [LANES-1:0]     lane_valid;
    logic                 lane_ready;
    vop_t                 lane_op;
    logic [REG_W-1:0]     lane_vs1;
    logic [REG_W-1:0]     lane_vs2;
    logic [REG_W-1:0]     lane_vd;
    logic [VL_W-1:0]      elem_base;
    logic                 stall_fetch;
    logic                 done;
    logic [REG_W-1:0]     done_vd;
    logic [PC_W-1:0]      done_pc;

    modport slave (
        input  in_valid, in_op, in_vs1, in_vs2, in_vd, in_vlen, in_pc,
`ifdef VSEQ_MASK_EN
        input  in_mask,
`endif
        input  lane_ready,
        output in_ready, lane_valid, lane_op, lane_vs1, lane_vs2, lane_vd,
        output elem_base, stall_fetch, done, done_vd, done_pc
    );

    modport master (
        output in_valid, in_op, in_vs1, in_vs2, in_vd, in_vlen, in_pc,
`ifdef VSEQ_MASK_EN
        output in_mask,
`endif
        output lane_ready,
        input  in_ready, lane_valid, lane_op, lane_vs1, lane_vs2, lane_vd,
        input  elem_base, stall_fetch, done, done_vd, done_pc
    );

endinterface

// File: rtl/vseq_drain_counter.sv
// Loadable down-counter with zero flag, times the lane pipeline drain.
// Latency: load/decrement visible the cycle after the edge.
// Backpressure: none; decrement saturates at zero.
module vseq_drain_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vector_issue_sequencer.sv
// Issues one vector instruction as LANES-wide element groups, drains the lane pipe, pulses done.
// Latency: ceil(vlen/LANES) issue cycles + PIPE_LAT drain + 1 done cycle (vlen=0: done next cycle).
// Backpressure: in_ready only in IDLE; lane_ready low freezes the current group. VSEQ_MASK_EN adds masking.
module vector_issue_sequencer
    import vproc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    vector_issue_sequencer_if.slave  sif
);

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    seq_state_t        state_q, state_d;
    vop_t              op_q;
    logic [REG_W-1:0]  vs1_q, vs2_q, vd_q;
    logic [PC_W-1:0]   pc_q;
    logic [VL_W-1:0]   vlen_q;
    logic [VL_W-1:0]   elem_base_q;
    logic [VL_W-1:0]   vlen_in;
    logic [VL_W:0]     grp_end;
    logic              accept, last_grp, drain_zero, drain_load;
    logic [LANES-1:0]  lane_valid;
`ifdef VSEQ_MASK_EN
    logic [NUM_ELEM-1:0] mask_q;
    logic [LANES-1:0]    mask_win;
`endif

    assign vlen_in    = clamp_vlen(sif.in_vlen);
    assign accept     = sif.in_valid && (state_q == S_IDLE);
    // One extra bit so base+LANES cannot wrap against vlen_q.
    assign grp_end    = {1'b0, elem_base_q} + (VL_W+1)'(LANES);
    assign last_grp   = grp_end >= {1'b0, vlen_q};
    assign drain_load = (state_q == S_ISSUE) && sif.lane_ready && last_grp;

    vseq_drain_counter #(.W(CNT_W)) u_drain (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (drain_load),
        .load_val (CNT_W'(PIPE_LAT - 1)),
        .dec      (state_q == S_DRAIN),
        .zero     (drain_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (vlen_in != '0) ? S_ISSUE : S_DONE;
            S_ISSUE: if (sif.lane_ready && last_grp) state_d = S_DRAIN;
            S_DRAIN: if (drain_zero) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            vd_q        <= '0;
            pc_q        <= '0;
            vlen_q      <= '0;
            elem_base_q <= '0;
`ifdef VSEQ_MASK_EN
            mask_q      <= '0;
`endif
        end else if (accept) begin
            op_q        <= sif.in_op;
            vs1_q       <= sif.in_vs1;
            vs2_q       <= sif.in_vs2;
            vd_q        <= sif.in_vd;
            pc_q        <= sif.in_pc;
            vlen_q      <= vlen_in;
            elem_base_q <= '0;
`ifdef VSEQ_MASK_EN
            mask_q      <= sif.in_mask;
`endif
        end else if ((state_q == S_ISSUE) && sif.lane_ready && !last_grp) begin
            elem_base_q <= elem_base_q + VL_W'(LANES);
        end
    end

    always_comb begin
        lane_valid = '0;
`ifdef VSEQ_MASK_EN
        mask_win   = LANES'(mask_q >> elem_base_q);
`endif
        for (int i = 0; i < LANES; i++) begin
            lane_valid[i] = (state_q == S_ISSUE) &&
                            (({1'b0, elem_base_q} + (VL_W+1)'(i)) < {1'b0, vlen_q});
`ifdef VSEQ_MASK_EN
            lane_valid[i] = lane_valid[i] && mask_win[i];
`endif
        end
    end

    assign sif.in_ready    = (state_q == S_IDLE);
    assign sif.stall_fetch = (state_q != S_IDLE);
    assign sif.done        = (state_q == S_DONE);
    assign sif.lane_valid  = lane_valid;
    assign sif.lane_op     = op_q;
    assign sif.lane_vs1    = vs1_q;
    assign sif.lane_vs2    = vs2_q;
    assign sif.lane_vd     = vd_q;
    assign sif.elem_base   = elem_base_q;
    assign sif.done_vd     = vd_q;
    assign sif.done_pc     = pc_q;

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed vector table plus a randomized run checked against an expected-trace model.
module tb_vector_issue_sequencer;
    import vproc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_issue_sequencer_if vif();

    vector_issue_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (vif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LANES-1:0] exp_lanes(input int vl, input int base,
                                                   input logic [NUM_ELEM-1:0] m);
        logic [LANES-1:0] r = '0;
        for (int i = 0; i < LANES; i++)
            r[i] = ((base + i) < vl) && m[base + i];
        return r;
    endfunction

    task automatic drive_junk();
        vif.in_op   = OP_W'($urandom);
        vif.in_vs1  = REG_W'($urandom);
        vif.in_vs2  = REG_W'($urandom);
        vif.in_vd   = REG_W'($urandom);
        vif.in_vlen = VL_W'($urandom);
        vif.in_pc   = PC_W'($urandom);
`ifdef VSEQ_MASK_EN
        vif.in_mask = NUM_ELEM'($urandom);
`endif
    endtask

    typedef struct {
        int                  vlen;
        logic [NUM_ELEM-1:0] mask;
        int                  stall;
        logic [LANES-1:0]    lv1;
        int                  b1;
        logic [LANES-1:0]    lv2;
        int                  b2;
        int                  done_cyc;
    } vec_t;

    task automatic run_vec(input vec_t v, input logic [REG_W-1:0] vd, input logic [PC_W-1:0] pc);
        @(negedge clk);
        drive_junk();
        vif.in_vd    = vd;
        vif.in_pc    = pc;
        vif.in_vlen  = VL_W'(v.vlen);
`ifdef VSEQ_MASK_EN
        vif.in_mask  = v.mask;
`endif
        vif.in_valid = 1'b1;
        chk("accept_in_ready", 32'(vif.in_ready), 32'd1);
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            vif.lane_ready = (c > v.stall);
            @(negedge clk);
            if (c <= v.stall + 1) begin
                chk($sformatf("v%0d_lv_c%0d", v.vlen, c), 32'(vif.lane_valid), 32'(v.lv1));
                chk($sformatf("v%0d_base_c%0d", v.vlen, c), 32'(vif.elem_base), 32'(v.b1));
            end else if (c == v.stall + 2) begin
                chk($sformatf("v%0d_lv_c%0d", v.vlen, c), 32'(vif.lane_valid), 32'(v.lv2));
                chk($sformatf("v%0d_base_c%0d", v.vlen, c), 32'(vif.elem_base), 32'(v.b2));
            end
            chk($sformatf("v%0d_stall_c%0d", v.vlen, c), 32'(vif.stall_fetch), 32'(c <= v.done_cyc));
            chk($sformatf("v%0d_inrdy_c%0d", v.vlen, c), 32'(vif.in_ready), 32'(c > v.done_cyc));
            chk($sformatf("v%0d_done_c%0d", v.vlen, c), 32'(vif.done), 32'(c == v.done_cyc));
            if (c == v.done_cyc) begin
                chk("done_vd", 32'(vif.done_vd), 32'(vd));
                chk("done_pc", 32'(vif.done_pc), 32'(pc));
            end
        end
    endtask

    typedef struct {
        logic                dv;
        logic                rdy;
        logic                present;
        logic                is_issue;
        logic                is_done;
        logic                exp_ready;
        logic                exp_stall;
        logic [LANES-1:0]    exp_lv;
        int                  exp_base;
        vop_t                op;
        logic [REG_W-1:0]    vs1, vs2, vd;
        logic [VL_W-1:0]     vlen;
        logic [PC_W-1:0]     pc;
        logic [NUM_ELEM-1:0] mask;
    } rec_t;

    rec_t recs[$];

    // Expands one random instruction into the cycle-by-cycle trace the lanes should see.
    task automatic gen_instr();
        rec_t r, base_r;
        int vl, ngrp;
        base_r = '{default: '0};
        base_r.op   = OP_W'($urandom);
        base_r.vs1  = REG_W'($urandom);
        base_r.vs2  = REG_W'($urandom);
        base_r.vd   = REG_W'($urandom);
        base_r.vlen = VL_W'($urandom_range(0, (1 << VL_W) - 1));
        base_r.pc   = PC_W'($urandom);
`ifdef VSEQ_MASK_EN
        base_r.mask = NUM_ELEM'($urandom);
`else
        base_r.mask = '1;
`endif
        vl   = (int'(base_r.vlen) > NUM_ELEM) ? NUM_ELEM : int'(base_r.vlen);
        ngrp = (vl + LANES - 1) / LANES;
        repeat ($urandom_range(0, 2)) begin
            r = base_r; r.exp_ready = 1'b1; r.rdy = 1'($urandom);
            recs.push_back(r);
        end
        r = base_r; r.dv = 1'b1; r.present = 1'b1; r.exp_ready = 1'b1;
        recs.push_back(r);
        for (int g = 0; g < ngrp; g++) begin
            r = base_r; r.is_issue = 1'b1; r.exp_stall = 1'b1;
            r.exp_base = g * LANES;
            r.exp_lv = exp_lanes(vl, g * LANES, base_r.mask);
            repeat ($urandom_range(0, 1) * $urandom_range(0, 2)) begin
                r.rdy = 1'b0; r.dv = 1'($urandom);
                recs.push_back(r);
            end
            r.rdy = 1'b1; r.dv = 1'($urandom);
            recs.push_back(r);
        end
        if (ngrp > 0) begin
            repeat (PIPE_LAT) begin
                r = base_r; r.exp_stall = 1'b1; r.rdy = 1'($urandom); r.dv = 1'($urandom);
                recs.push_back(r);
            end
        end
        r = base_r; r.exp_stall = 1'b1; r.is_done = 1'b1; r.dv = 1'($urandom);
        recs.push_back(r);
    endtask

    task automatic run_random(input int n_instr);
        rec_t r;
        for (int k = 0; k < n_instr; k++) gen_instr();
        while (recs.size() > 0) begin
            r = recs.pop_front();
            @(posedge clk);
            #1;
            drive_junk();
            if (r.present) begin
                vif.in_op   = r.op;
                vif.in_vs1  = r.vs1;
                vif.in_vs2  = r.vs2;
                vif.in_vd   = r.vd;
                vif.in_vlen = r.vlen;
                vif.in_pc   = r.pc;
`ifdef VSEQ_MASK_EN
                vif.in_mask = r.mask;
`endif
            end
            vif.in_valid   = r.dv;
            vif.lane_ready = r.rdy;
            @(negedge clk);
            chk("rnd_in_ready", 32'(vif.in_ready), 32'(r.exp_ready));
            chk("rnd_stall", 32'(vif.stall_fetch), 32'(r.exp_stall));
            chk("rnd_lane_valid", 32'(vif.lane_valid), 32'(r.exp_lv));
            chk("rnd_done", 32'(vif.done), 32'(r.is_done));
            if (r.is_issue) begin
                chk("rnd_elem_base", 32'(vif.elem_base), 32'(r.exp_base));
                chk("rnd_lane_op", 32'(vif.lane_op), 32'(r.op));
                chk("rnd_lane_vs1", 32'(vif.lane_vs1), 32'(r.vs1));
                chk("rnd_lane_vs2", 32'(vif.lane_vs2), 32'(r.vs2));
                chk("rnd_lane_vd", 32'(vif.lane_vd), 32'(r.vd));
            end
            if (r.is_done) begin
                chk("rnd_done_vd", 32'(vif.done_vd), 32'(r.vd));
                chk("rnd_done_pc", 32'(vif.done_pc), 32'(r.pc));
            end
        end
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(vif.in_ready), 32'd1);
        chk({tag, "_stall"}, 32'(vif.stall_fetch), 32'd0);
        chk({tag, "_lane_valid"}, 32'(vif.lane_valid), 32'd0);
        chk({tag, "_elem_base"}, 32'(vif.elem_base), 32'd0);
        chk({tag, "_done"}, 32'(vif.done), 32'd0);
        chk({tag, "_done_vd"}, 32'(vif.done_vd), 32'd0);
        chk({tag, "_done_pc"}, 32'(vif.done_pc), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{vlen: 8,  mask: '1, stall: 0, lv1: 4'hF, b1: 0, lv2: 4'hF, b2: 4, done_cyc: 6});
        vecs.push_back('{vlen: 5,  mask: '1, stall: 0, lv1: 4'hF, b1: 0, lv2: 4'h1, b2: 4, done_cyc: 6});
        vecs.push_back('{vlen: 0,  mask: '1, stall: 0, lv1: 4'h0, b1: 0, lv2: 4'h0, b2: 0, done_cyc: 1});
        vecs.push_back('{vlen: 12, mask: '1, stall: 0, lv1: 4'hF, b1: 0, lv2: 4'hF, b2: 4, done_cyc: 6});
        vecs.push_back('{vlen: 8,  mask: '1, stall: 2, lv1: 4'hF, b1: 0, lv2: 4'hF, b2: 4, done_cyc: 8});
        vecs.push_back('{vlen: 3,  mask: '1, stall: 0, lv1: 4'h7, b1: 0, lv2: 4'h0, b2: 0, done_cyc: 5});
        vecs.push_back('{vlen: 4,  mask: '1, stall: 1, lv1: 4'hF, b1: 0, lv2: 4'h0, b2: 0, done_cyc: 6});
`ifdef VSEQ_MASK_EN
        vecs.push_back('{vlen: 8,  mask: 8'b0101_0000, stall: 0, lv1: 4'h0, b1: 0, lv2: 4'h5, b2: 4, done_cyc: 6});
        vecs.push_back('{vlen: 5,  mask: 8'b0001_1110, stall: 0, lv1: 4'hE, b1: 0, lv2: 4'h1, b2: 4, done_cyc: 6});
`endif

        vif.in_valid   = 1'b0;
        vif.lane_ready = 1'b0;
        drive_junk();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++)
            run_vec(vecs[k], REG_W'(k + 3), PC_W'(21'h1_2340 + k));

        // Reset while issuing the second group abandons the instruction.
        @(negedge clk);
        vif.in_vlen = VL_W'(8); vif.in_vd = 4'hA; vif.in_pc = 21'h0_BEEF;
`ifdef VSEQ_MASK_EN
        vif.in_mask = '1;
`endif
        vif.in_valid = 1'b1;
        @(posedge clk);
        #1 vif.in_valid = 1'b0; vif.lane_ready = 1'b1;
        @(negedge clk);
        chk("rst_pre_lv", 32'(vif.lane_valid), 32'hF);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_c2_base", 32'(vif.elem_base), 32'd4);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(vif.done), 32'd0);
        end
        run_vec(vecs[0], 4'h5, 21'h1_F00D);

        run_random(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
